// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one 128-bit block memory between I-cache reads and D-cache reads/write-backs.
// Transfer takes grant + 2 cycles + memory busy time; requesters stall on *_BUSYWAIT. `ARB_TIMEOUT_EN adds a WAIT watchdog.
module mem_bus_arbiter #(
    parameter int ADDR_W         = 28,
    parameter int BLOCK_W        = 128,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_ADDRESS,
    output logic [BLOCK_W-1:0] I_READDATA,
    output logic               I_BUSYWAIT,
    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_ADDRESS,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               D_BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT,
    output logic               ARB_ERROR
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_owner;
    logic               r_last_grant;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [ADDR_W-1:0]  r_mem_address;
    logic [BLOCK_W-1:0] r_mem_writedata;
    logic [BLOCK_W-1:0] r_i_readdata;
    logic [BLOCK_W-1:0] r_d_readdata;
    logic               w_req_i;
    logic               w_req_d;
    logic               w_grant;
    logic               w_grant_d;
    logic               w_mem_ready;
    logic               w_timeout;
    logic               w_done;

    assign w_req_i     = I_READ;
    assign w_req_d     = D_READ | D_WRITE;
    assign w_grant     = w_req_i | w_req_d;
    // On a tie the requester that did not finish last wins.
    assign w_grant_d   = w_req_d & (~w_req_i | (r_last_grant == OWN_I));
    assign w_mem_ready = ~MEM_BUSYWAIT;
    assign w_done      = (r_state == DONE);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_arb_error;

    // Counter holds the number of WAIT edges already spent, so the limit fires on the last allowed edge.
    assign w_timeout = MEM_BUSYWAIT & (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wait_cnt  <= '0;
            r_arb_error <= 1'b0;
        end else begin
            if (r_state == ISSUE)
                r_wait_cnt <= '0;
            else if (r_state == WAIT)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if ((r_state == WAIT) && w_timeout)
                r_arb_error <= 1'b1;
        end
    end
    assign ARB_ERROR = r_arb_error;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
    assign ARB_ERROR        = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_next_state = ISSUE;
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (w_mem_ready || w_timeout) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_owner         <= OWN_I;
            r_last_grant    <= OWN_I;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_i_readdata    <= '0;
            r_d_readdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_grant_d;
                        if (w_grant_d) begin
                            // Read+write together is a write-back.
                            r_mem_address <= D_ADDRESS;
                            r_mem_write   <= D_WRITE;
                            r_mem_read    <= ~D_WRITE;
                            if (D_WRITE)
                                r_mem_writedata <= D_WRITEDATA;
                        end else begin
                            r_mem_address <= I_ADDRESS;
                            r_mem_read    <= 1'b1;
                            r_mem_write   <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (w_mem_ready || w_timeout) begin
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_last_grant <= r_owner;
                        if (w_mem_ready && r_mem_read) begin
                            if (r_owner == OWN_D)
                                r_d_readdata <= MEM_READDATA;
                            else
                                r_i_readdata <= MEM_READDATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign I_BUSYWAIT    = w_req_i & ~(w_done & (r_owner == OWN_I));
    assign D_BUSYWAIT    = w_req_d & ~(w_done & (r_owner == OWN_D));
    assign I_READDATA    = r_i_readdata;
    assign D_READDATA    = r_d_readdata;
    assign MEM_READ      = r_mem_read;
    assign MEM_WRITE     = r_mem_write;
    assign MEM_ADDRESS   = r_mem_address;
    assign MEM_WRITEDATA = r_mem_writedata;
endmodule
